// File: rtl/rx_stat_meter.sv
// rtl/rx_stat_meter.sv - per-port rx statistics: pps, throughput, latency and last source IPv4 per gate window
// Optional build macro RX_STAT_MAXLAT_EN: latency reports the window maximum instead of the last sample.
module rx_stat_meter #(
  parameter int GATE_TICKS     = 156250000,
  parameter int OVERHEAD_BYTES = 20,
  parameter int TS_W           = 24
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            frame_valid,
  input  logic            frame_ok,
  input  logic [15:0]     frame_len,
  input  logic [31:0]     src_ip,
  input  logic            ts_valid,
  input  logic [TS_W-1:0] ts_tx,
  input  logic [TS_W-1:0] ts_now,
  input  logic            stat_clr,
  output logic [31:0]     pps,
  output logic [31:0]     throughput,
  output logic [TS_W-1:0] latency,
  output logic [31:0]     ipv4_ip,
  output logic            gate_tick
);

  localparam int CW = $clog2(GATE_TICKS);
  localparam logic [CW-1:0] TERM_CNT = CW'(GATE_TICKS - 1);

  logic [CW-1:0]   gate_cnt;
  logic [31:0]     frm_acc;
  logic [31:0]     byte_acc;
  logic [TS_W-1:0] lat_acc;
  logic            lat_seen;
  logic [TS_W-1:0] lat_s;
  logic            lat_s_valid;

  logic            good;
  logic            term;
  logic [31:0]     frm_nxt;
  logic [32:0]     byte_sum;
  logic [31:0]     byte_nxt;
  logic [TS_W-1:0] lat_base;
  logic            seen_base;
  logic [TS_W-1:0] lat_acc_nxt;
  logic            lat_seen_nxt;

  assign good = frame_valid & frame_ok;
  assign term = (gate_cnt == TERM_CNT);

  // Next accumulator values including the current event; both counters saturate instead of wrapping.
  always_comb begin
    frm_nxt  = frm_acc;
    byte_sum = {1'b0, byte_acc} + 33'(frame_len) + 33'(OVERHEAD_BYTES);
    byte_nxt = byte_acc;
    if (good) begin
      if (frm_acc != 32'hFFFF_FFFF) frm_nxt = frm_acc + 32'd1;
      byte_nxt = byte_sum[32] ? 32'hFFFF_FFFF : byte_sum[31:0];
    end
  end

  // Latency tracker update; a sample leaving the pipeline on the close cycle seeds the next window.
  always_comb begin
    lat_base     = term ? '0 : lat_acc;
    seen_base    = term ? 1'b0 : lat_seen;
    lat_acc_nxt  = lat_base;
    lat_seen_nxt = seen_base;
    if (lat_s_valid) begin
      lat_seen_nxt = 1'b1;
`ifdef RX_STAT_MAXLAT_EN
      lat_acc_nxt = (lat_s > lat_base) ? lat_s : lat_base;
`else
      lat_acc_nxt = lat_s;
`endif
    end
  end

  // One-cycle latency sample stage: wrapping difference of local and embedded timestamps.
  always_ff @(posedge clk) begin
    if (!rst_n || stat_clr) begin
      lat_s       <= '0;
      lat_s_valid <= 1'b0;
    end else begin
      lat_s       <= ts_now - ts_tx;
      lat_s_valid <= good & ts_valid;
    end
  end

  // Gate counter, accumulators and registered result outputs; clear beats any event or close.
  always_ff @(posedge clk) begin
    if (!rst_n || stat_clr) begin
      gate_cnt   <= '0;
      frm_acc    <= '0;
      byte_acc   <= '0;
      lat_acc    <= '0;
      lat_seen   <= 1'b0;
      pps        <= '0;
      throughput <= '0;
      latency    <= '0;
      ipv4_ip    <= '0;
      gate_tick  <= 1'b0;
    end else begin
      gate_tick <= term;
      lat_acc   <= lat_acc_nxt;
      lat_seen  <= lat_seen_nxt;
      if (good) ipv4_ip <= src_ip;
      if (term) begin
        gate_cnt   <= '0;
        pps        <= frm_nxt;
        throughput <= byte_nxt;
        if (lat_seen) latency <= lat_acc;
        frm_acc    <= '0;
        byte_acc   <= '0;
      end else begin
        gate_cnt <= gate_cnt + 1'b1;
        frm_acc  <= frm_nxt;
        byte_acc <= byte_nxt;
      end
    end
  end

endmodule

// File: tb/tb_rx_stat_meter.sv
// tb/tb_rx_stat_meter.sv - directed self-checking bench for rx_stat_meter (honours RX_STAT_MAXLAT_EN)
module tb_rx_stat_meter;

  localparam int TS_W = 24;
  localparam int BIG_GATE = 70000;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            frame_valid;
  logic            frame_ok;
  logic [15:0]     frame_len;
  logic [31:0]     src_ip;
  logic            ts_valid;
  logic [TS_W-1:0] ts_tx;
  logic [TS_W-1:0] ts_now;
  logic            stat_clr;
  logic [31:0]     pps;
  logic [31:0]     throughput;
  logic [TS_W-1:0] latency;
  logic [31:0]     ipv4_ip;
  logic            gate_tick;

  logic            rst2_n;
  logic [31:0]     pps2;
  logic [31:0]     thr2;
  logic [TS_W-1:0] lat2;
  logic [31:0]     ip2;
  logic            tick2;

  int total = 0;
  int bad   = 0;
  int n;

  always #5 clk = ~clk;

  rx_stat_meter #(.GATE_TICKS(100), .OVERHEAD_BYTES(20), .TS_W(TS_W)) dut (
    .clk(clk), .rst_n(rst_n), .frame_valid(frame_valid), .frame_ok(frame_ok),
    .frame_len(frame_len), .src_ip(src_ip), .ts_valid(ts_valid), .ts_tx(ts_tx),
    .ts_now(ts_now), .stat_clr(stat_clr), .pps(pps), .throughput(throughput),
    .latency(latency), .ipv4_ip(ipv4_ip), .gate_tick(gate_tick)
  );

  // Second instance: a full-size frame on every cycle over a long window to reach byte saturation.
  rx_stat_meter #(.GATE_TICKS(BIG_GATE), .OVERHEAD_BYTES(20), .TS_W(TS_W)) dut_sat (
    .clk(clk), .rst_n(rst2_n), .frame_valid(1'b1), .frame_ok(1'b1),
    .frame_len(16'hFFFF), .src_ip(32'h0), .ts_valid(1'b0), .ts_tx('0),
    .ts_now('0), .stat_clr(1'b0), .pps(pps2), .throughput(thr2),
    .latency(lat2), .ipv4_ip(ip2), .gate_tick(tick2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic ok, input logic [15:0] len, input logic [31:0] ip,
                      input logic tsv, input logic [TS_W-1:0] tx, input logic [TS_W-1:0] now);
    frame_valid = 1'b1; frame_ok = ok; frame_len = len; src_ip = ip;
    ts_valid = tsv; ts_tx = tx; ts_now = now;
    tick();
    frame_valid = 1'b0; frame_ok = 1'b0; ts_valid = 1'b0;
  endtask

  task automatic wait_gate(input string tag);
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (!gate_tick && k < 300);
    chk({tag, "_gate_seen"}, 32'(gate_tick), 32'd1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pps"}, pps, 32'd0);
    chk({tag, "_thr"}, throughput, 32'd0);
    chk({tag, "_lat"}, 32'(latency), 32'd0);
    chk({tag, "_ip"}, ipv4_ip, 32'd0);
    chk({tag, "_tick"}, 32'(gate_tick), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; rst2_n = 1'b0; stat_clr = 1'b0;
    frame_valid = 1'b0; frame_ok = 1'b0; frame_len = '0; src_ip = '0;
    ts_valid = 1'b0; ts_tx = '0; ts_now = '0;
    tick(); tick();
    chk_zero("reset");
    rst_n = 1'b1; rst2_n = 1'b1;

    // first window empty
    wait_gate("w0");
    chk("w0_pps", pps, 32'd0);

    // 10 back-to-back good frames of 64 bytes
    for (int i = 0; i < 10; i++) send(1'b1, 16'd64, 32'h0102_0304, 1'b0, '0, '0);
    wait_gate("w1");
    chk("w1_pps", pps, 32'd10);
    chk("w1_thr", throughput, 32'd840);

    wait_gate("w2");
    chk("w2_pps", pps, 32'd0);
    chk("w2_thr", throughput, 32'd0);
    chk("w2_ip", ipv4_ip, 32'h0102_0304);

    // bad frames interleaved with three good 1518-byte frames
    send(1'b0, 16'd1518, 32'hDEAD_BEEF, 1'b0, '0, '0);
    send(1'b1, 16'd1518, 32'h0A00_0001, 1'b0, '0, '0);
    send(1'b0, 16'd1518, 32'hDEAD_BEEF, 1'b0, '0, '0);
    send(1'b1, 16'd1518, 32'h0A00_0002, 1'b0, '0, '0);
    send(1'b0, 16'd1518, 32'hDEAD_BEEF, 1'b0, '0, '0);
    send(1'b0, 16'd1518, 32'hDEAD_BEEF, 1'b0, '0, '0);
    send(1'b1, 16'd1518, 32'h0A00_1569, 1'b0, '0, '0);
    send(1'b0, 16'd1518, 32'hDEAD_BEEF, 1'b0, '0, '0);
    wait_gate("w3");
    chk("w3_pps", pps, 32'd3);
    chk("w3_thr", throughput, 32'd4614);
    chk("w3_ip", ipv4_ip, 32'h0A00_1569);

    // frame on the terminal cycle belongs to the closing window
    send(1'b1, 16'd100, 32'h0A00_1569, 1'b0, '0, '0);
    send(1'b1, 16'd100, 32'h0A00_1569, 1'b0, '0, '0);
    repeat (97) tick();
    send(1'b1, 16'd100, 32'h0A00_1569, 1'b0, '0, '0);
    chk("term_tick", 32'(gate_tick), 32'd1);
    chk("term_pps", pps, 32'd3);
    chk("term_thr", throughput, 32'd360);
    wait_gate("w5");
    chk("w5_pps", pps, 32'd0);
    chk("w5_thr", throughput, 32'd0);

    // wrapping latency
    send(1'b1, 16'd64, 32'h0B00_0001, 1'b1, 24'hFFFFF0, 24'h000010);
    wait_gate("lat1");
    chk("lat1_lat", 32'(latency), 32'h20);

    // samples 5, 40, 12
    send(1'b1, 16'd64, 32'h0B00_0002, 1'b1, 24'h0, 24'd5);
    send(1'b1, 16'd64, 32'h0B00_0003, 1'b1, 24'h0, 24'd40);
    send(1'b1, 16'd64, 32'h0B00_0004, 1'b1, 24'h0, 24'd12);
    wait_gate("lat2");
`ifdef RX_STAT_MAXLAT_EN
    chk("lat2_lat", 32'(latency), 32'd40);
`else
    chk("lat2_lat", 32'(latency), 32'd12);
`endif
    chk("lat2_pps", pps, 32'd3);

    // no good samples: latency holds; bad frame with timestamp ignored
    send(1'b0, 16'd64, 32'hDEAD_BEEF, 1'b1, 24'h0, 24'h777);
    wait_gate("lat3");
`ifdef RX_STAT_MAXLAT_EN
    chk("lat3_lat", 32'(latency), 32'd40);
`else
    chk("lat3_lat", 32'(latency), 32'd12);
`endif
    chk("lat3_pps", pps, 32'd0);
    chk("lat3_ip", ipv4_ip, 32'h0B00_0004);

    // stat_clr mid-window with coincident good frame
    for (int i = 0; i < 3; i++) send(1'b1, 16'd64, 32'h0C00_0001, 1'b1, 24'h0, 24'd9);
    repeat (20) tick();
    stat_clr = 1'b1;
    send(1'b1, 16'd64, 32'h0C00_0002, 1'b1, 24'h0, 24'd7);
    stat_clr = 1'b0;
    chk_zero("clr");
    n = 0;
    do begin
      tick();
      n++;
    end while (!gate_tick && n < 300);
    chk("clr_gate_dist", 32'(n), 32'd100);
    chk("clr_pps", pps, 32'd0);
    chk("clr_thr", throughput, 32'd0);
    chk("clr_lat", 32'(latency), 32'd0);

    // reset mid-window
    send(1'b1, 16'd64, 32'h0D00_0001, 1'b1, 24'h0, 24'd3);
    send(1'b1, 16'd64, 32'h0D00_0002, 1'b1, 24'h0, 24'd4);
    wait_gate("pre_rst");
    send(1'b1, 16'd64, 32'h0D00_0003, 1'b1, 24'h0, 24'd5);
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    chk_zero("rst_mid");
    rst_n = 1'b1;
    wait_gate("post_rst");
    chk("post_rst_pps", pps, 32'd0);
    chk("post_rst_lat", 32'(latency), 32'd0);

    // byte counter saturation on the long-window instance
    n = 0;
    while (!tick2 && n < BIG_GATE + 1000) begin
      tick();
      n++;
    end
    chk("sat_tick", 32'(tick2), 32'd1);
    chk("sat_pps", pps2, 32'(BIG_GATE));
    chk("sat_thr", thr2, 32'hFFFF_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rx_stat_meter.md
Name: rx_stat_meter

Overview:
- Per-port receive statistics engine; one instance per rx port (rx1..rx3), plus one on tx0 with the timestamp inputs tied off.
- Consumes end-of-frame events from the Ethernet datapath and accumulates frames and bytes over a fixed gate window.
- At each window boundary it latches pps, throughput and latency into stable outputs that feed the PCIe user-register read mux directly.
- Also tracks the source IPv4 address of the last good frame.

Parameters:
GATE_TICKS, 156250000, clk cycles per measurement window (1 s at 156.25 MHz); must be >= 2
OVERHEAD_BYTES, 20, bytes added per frame for preamble+SFD+IFG in throughput
TS_W, 24, timestamp/latency width in bits

Ports:
clk  in  1  datapath clock
rst_n  in  1  synchronous active-low reset
frame_valid  in  1  one-cycle pulse at end of each received frame
frame_ok  in  1  qualifies frame_valid; FCS/length good
frame_len  in  16  frame length in bytes, valid with frame_valid
src_ip  in  32  IPv4 source address, valid with frame_valid
ts_valid  in  1  frame carried a tx timestamp, valid with frame_valid
ts_tx  in  TS_W  embedded tx timestamp
ts_now  in  TS_W  free-running local timestamp counter
stat_clr  in  1  one-cycle clear pulse from register write
pps  out  32  good frames in last completed window
throughput  out  32  bytes (frame_len+OVERHEAD_BYTES) in last completed window
latency  out  TS_W  latency result for last completed window
ipv4_ip  out  32  src_ip of most recent good frame
gate_tick  out  1  one-cycle pulse when the window closes

Behaviour:
- Reset: clk and rst_n are synchronous, active-low. All outputs, the gate counter and all accumulators go to 0.
- Event: "good" = frame_valid & frame_ok. frame_valid & !frame_ok is ignored entirely.
- Gate counter:
  - Counts 0..GATE_TICKS-1 and wraps.
  - The terminal cycle is gate_cnt==GATE_TICKS-1. gate_tick is registered and asserts the cycle after the terminal cycle, coincident with new pps/throughput/latency values.
- Accumulators:
  - frm_acc (32b) +1 per good event.
  - byte_acc (32b) += frame_len+OVERHEAD_BYTES, computed in 33b and saturating at 32'hFFFFFFFF.
  - frm_acc also saturates.
- Latency sample:
  - On a good event with ts_valid: lat_s = (ts_now - ts_tx) mod 2^TS_W, registered one cycle after the event. No sign handling; wrap is intended.
  - lat_acc holds the most recent sample in the window.
  - lat_seen flags that at least one sample occurred.
- Window close (terminal cycle):
  - pps, throughput and latency update 1 cycle later from the accumulators, including any event presented on the terminal cycle itself.
  - The accumulators restart from 0 on the next cycle.
  - If lat_seen=0, latency holds its previous value.
  - A latency sample still in its pipeline stage at close belongs to the next window.
- ipv4_ip: updated the cycle after every good event, independent of the gate.
- stat_clr:
  - Zeroes the accumulators, lat_seen, gate_cnt and all outputs next cycle, with priority over any event or close on the same cycle.
  - An event coincident with stat_clr is dropped.
- Outputs are registered; no combinational path from inputs to outputs.
- Back-to-back good events on consecutive cycles are all counted; no stall or ready signal exists.

Optional Feature:
- Macro: RX_STAT_MAXLAT_EN.
- Defined: lat_acc tracks the maximum lat_s within the window (unsigned compare), reset to 0 at each window close; latency = window maximum.
- Undefined: latency = last sample in window, as described in Behaviour.
- All other behaviour is identical in both builds.

Test Plan:
- GATE_TICKS=100, OVERHEAD_BYTES=20: 10 good frames of len 64 within one window -> after gate_tick, pps=10, throughput=840; next empty window -> pps=0, throughput=0.
- 5 frames with frame_ok=0 interleaved with 3 good frames of len 1518, src_ip=0x0A001569 on the last good one -> pps=3, throughput=4614, ipv4_ip=0x0A001569.
- Good frame on the terminal cycle (gate_cnt=99) -> counted in the closing window (pps includes it); the following window starts at 0.
- ts_now=0x000010, ts_tx=0xFFFFF0 with ts_valid -> latency=0x000020 after close. With RX_STAT_MAXLAT_EN, samples 5,40,12 -> latency=40; without it -> 12. A window with no samples -> latency unchanged.
- frame_len=0xFFFF on every cycle with GATE_TICKS large -> throughput saturates at 0xFFFFFFFF with no wrap.
- stat_clr coincident with a good frame and mid-window -> all outputs 0 next cycle, frame not counted, gate restarts (gate_tick 100 cycles later); rst_n low mid-window -> same zero state.
